// File: rtl/muldiv_unit_if.sv
// Execute-stage mul/div bus: launch, operands, MTHI/MTLO writes and HI/LO results.
// The pipeline side (master) drives requests; the unit (slave) returns HI/LO and status.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b, hi_we, lo_we, wd,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wd,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, owning the HI/LO registers.
// Signed ops run on magnitudes; the sign is restored in the FIX cycle before commit.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CW    = 6
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state_reg;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   opnd_reg;
   logic               is_div_reg;
   logic               sign_q_reg;
   logic               sign_r_reg;
   logic               div_zero_reg;
   logic [WIDTH-1:0]   hi_reg;
   logic [WIDTH-1:0]   lo_reg;
   logic               busy_reg;
   logic               done_reg;

   logic               is_signed;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;

   assign is_signed = bus.op[0];
   assign a_abs     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_abs     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply step: acc holds {partial product, remaining multiplier bits}.
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_addend
         assign addend[gi] = opnd_reg[gi] & acc_reg[0];
      end
   endgenerate

   assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
   assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

   // Restoring divide step: acc holds {remainder, dividend bits shifting into quotient}.
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;

   assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, opnd_reg};
   assign div_next  = div_diff[WIDTH]
                    ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                    : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

   // Sign restoration; a zero divisor leaves remainder = dividend, which re-signs back to raw a.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign prod_fix = sign_q_reg ? -acc_reg : acc_reg;
   assign quo      = acc_reg[WIDTH-1:0];
   assign rem      = acc_reg[2*WIDTH-1:WIDTH];
   assign quo_fix  = div_zero_reg ? {WIDTH{1'b1}} : (sign_q_reg ? -quo : quo);
   assign rem_fix  = sign_r_reg ? -rem : rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         acc_reg      <= '0;
         opnd_reg     <= '0;
         is_div_reg   <= 1'b0;
         sign_q_reg   <= 1'b0;
         sign_r_reg   <= 1'b0;
         div_zero_reg <= 1'b0;
         hi_reg       <= '0;
         lo_reg       <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.hi_we) hi_reg <= bus.wd;
               if (bus.lo_we) lo_reg <= bus.wd;
               if (bus.start) begin
                  is_div_reg   <= bus.op[1];
                  sign_q_reg   <= is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  sign_r_reg   <= is_signed & bus.a[WIDTH-1];
                  div_zero_reg <= bus.op[1] && (bus.b == '0);
                  acc_reg      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs : b_abs)};
                  opnd_reg     <= bus.op[1] ? b_abs : a_abs;
                  cnt_reg      <= '0;
                  busy_reg     <= 1'b1;
                  state_reg    <= CALC;
               end
            end
            CALC: begin
               acc_reg <= is_div_reg ? div_next : mul_next;
               cnt_reg <= cnt_reg + CW'(1);
               if (cnt_reg == CW'(WIDTH-1)) state_reg <= FIX;
            end
            FIX: begin
               if (is_div_reg) begin
                  hi_reg <= rem_fix;
                  lo_reg <= quo_fix;
               end else begin
                  hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_reg <= prod_fix[WIDTH-1:0];
               end
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.hi   = hi_reg;
   assign bus.lo   = lo_reg;
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32), .CW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned accept;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; returns {hi, lo}.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb_v, q, r;
      logic [63:0] res;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      case (op)
         2'b00: res = {32'h0, a} * {32'h0, b};
         2'b01: res = 64'(sa * sb_v);
         2'b10: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb_v;
               r   = sa % sb_v;
               res = {r[31:0], q[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // Called just after a negedge; start is sampled on the following posedge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_result);
      exp_t        e;
      logic [63:0] r;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      if (expect_result) begin
         r        = model(op, a, b);
         e.op     = op;
         e.a      = a;
         e.b      = b;
         e.hi     = r[63:32];
         e.lo     = r[31:0];
         e.accept = cyc + 1;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 64'(seen), 64'd1);
   endtask

   // Monitor: pops the scoreboard on every done pulse and polices pulse width and HI/LO hold.
   logic        prev_done = 1'b0;
   logic        prev_busy = 1'b0;
   logic [31:0] prev_hi   = '0;
   logic [31:0] prev_lo   = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (prev_done) check("done_width", 64'(bus.done), 64'd0);
         if (prev_busy && bus.busy) check("hold_busy", {bus.hi, bus.lo}, {prev_hi, prev_lo});
         if (bus.done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               check("hi", 64'(bus.hi), 64'(e.hi));
               check("lo", 64'(bus.lo), 64'(e.lo));
               check("latency", 64'(cyc), 64'(e.accept + 33));
               $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h (exp hi=%h lo=%h)",
                        e.op, e.a, e.b, bus.hi, bus.lo, e.hi, e.lo);
            end
         end
         prev_done = bus.done;
         prev_busy = bus.busy;
      end else begin
         prev_done = 1'b0;
         prev_busy = 1'b0;
      end
      prev_hi = bus.hi;
      prev_lo = bus.lo;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n;
      logic [31:0] saved_lo;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          sel;

      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.a     = '0;
      bus.b     = '0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      bus.wd    = '0;

      repeat (3) @(negedge clk);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      // Idle MTHI / MTLO.
      bus.hi_we = 1'b1;
      bus.wd    = 32'h0000_AAAA;
      @(negedge clk);
      bus.hi_we = 1'b0;
      check("mthi", 64'(bus.hi), 64'h0000_AAAA);
      bus.lo_we = 1'b1;
      bus.wd    = 32'h0000_5555;
      @(negedge clk);
      bus.lo_we = 1'b0;
      check("mtlo", 64'(bus.lo), 64'h0000_5555);
      check("mtlo_hi_kept", 64'(bus.hi), 64'h0000_AAAA);
      $display("txn mthi/mtlo hi=%h lo=%h", bus.hi, bus.lo);

      // Asynchronous reset mid-CALC aborts MULTU 7*9.
      issue(2'b00, 32'd7, 32'd9, 1'b0);
      repeat (10) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_hi", 64'(bus.hi), 64'd0);
      check("abort_lo", 64'(bus.lo), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (40) @(negedge clk);
      check("abort_hi_after", 64'(bus.hi), 64'd0);
      check("abort_lo_after", 64'(bus.lo), 64'd0);
      $display("txn reset-abort hi=%h lo=%h", bus.hi, bus.lo);

      // MULT -3*5 with busy length.
      issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1);
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", 64'(n), 64'd33);
      check("done_after_busy", 64'(bus.done), 64'd1);

      // MULTU max, then DIVU 100/7 issued in the done cycle.
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      wait_done();
      issue(2'b10, 32'd100, 32'd7, 1'b1);
      wait_done();

      issue(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done();
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      wait_done();
      issue(2'b10, 32'h0000_1234, 32'd0, 1'b1);
      wait_done();

      // Start and MTHI in the same cycle: write lands now, result overwrites at commit.
      bus.hi_we = 1'b1;
      bus.wd    = 32'h0000_BEEF;
      issue(2'b11, 32'hFFFF_FF00, 32'd3, 1'b1);
      check("start_plus_mthi", 64'(bus.hi), 64'h0000_BEEF);
      wait_done();

      // start and lo_we while busy are both ignored.
      issue(2'b00, 32'd2, 32'd3, 1'b1);
      repeat (5) @(negedge clk);
      saved_lo  = bus.lo;
      bus.start = 1'b1;
      bus.op    = 2'b10;
      bus.a     = 32'd100;
      bus.b     = 32'd7;
      bus.lo_we = 1'b1;
      bus.wd    = 32'hDEAD_0000;
      @(negedge clk);
      bus.start = 1'b0;
      bus.lo_we = 1'b0;
      check("busy_lo_we_ignored", 64'(bus.lo), 64'(saved_lo));
      wait_done();
      repeat (40) @(negedge clk);
      check("no_queued_start", 64'(bus.busy), 64'd0);

      // Random ops with corner-biased operands.
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin
            ra = 32'h8000_0000;
            rb = 32'hFFFF_FFFF;
         end else if (sel == 2) rb = 32'($urandom_range(1, 15));
         else if (sel == 3) ra = 32'($urandom_range(0, 15));
         issue(rop, ra, rb, 1'b1);
         wait_done();
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the execute stage. Replaces the single-cycle combinational multiplier and the hi/lo register pair.
- Executes MULT, MULTU, DIV and DIVU on the forwarded execute-stage operands, one bit per cycle. It also services MTHI and MTLO.
- Holds the architectural HI/LO values and drives the HI/LO read data consumed by the memory-stage write-data mux.
- Raises busy so the hazard unit stalls any MFHI, MFLO, MTHI, MTLO or mul/div instruction that arrives while an operation is in flight.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- CW, 6, iteration counter width. Must satisfy 2^CW > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  launch the operation selected by op; sampled only in IDLE.
- op  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wd  in  WIDTH  MTHI/MTLO write data.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- busy  out  1  operation in flight; the hazard unit uses it to stall.
- done  out  1  single-cycle pulse when a result has been committed to HI/LO.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hi=lo=0; busy=0; done=0; counter and datapath registers=0.
  - Reset asserted mid-operation aborts it: no partial result reaches hi/lo.
- States: IDLE, CALC, FIX.
  - IDLE, start=1: latch op and |a|, |b|. Absolute value applies only to signed ops; unsigned ops use raw values. Record sign_q = a[msb]^b[msb] and sign_r = a[msb] (signed ops only). Clear accumulator, cnt=0, go to CALC.
  - CALC: one iteration per cycle; cnt increments each cycle. When cnt==WIDTH-1, go to FIX.
    - Multiply: shift-add over a 2*WIDTH product register, LSB of multiplier first.
    - Divide: restoring, MSB of dividend first. Trial subtract the divisor from the partial remainder; the quotient bit is 1 when the result is non-negative.
  - FIX: apply the sign correction and write hi/lo; go to IDLE with done=1 for exactly one cycle.
    - Signed multiply: negate the 2*WIDTH product if sign_q. hi=product[2W-1:W], lo=product[W-1:0].
    - Division: lo=quotient, hi=remainder. For signed ops, negate the quotient if sign_q and the remainder if sign_r.
- Latency: start sampled at edge 0; CALC occupies edges 1..WIDTH; FIX writes hi/lo at edge WIDTH+1 (33 for the default). busy=1 from after edge 0 until edge WIDTH+1, i.e. WIDTH+1 cycles. done=1 in the cycle after the commit edge.
- busy is registered: busy=(state!=IDLE).
- Back-to-back: start is accepted in the same cycle done=1, because the unit is in IDLE.
- start while busy: ignored. It does not queue and does not change op or operands.
- hi_we/lo_we:
  - Honoured only in IDLE; writes on the next edge.
  - When start and a write are both asserted in the same cycle, both take effect. The later mul/div result overwrites that register at FIX.
  - While busy, hi_we/lo_we are ignored; the hazard unit must stall.
- Divide by zero (b==0, any div op): no fault. The unit still takes the full latency and commits hi=a (raw input) and lo={WIDTH{1}}.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: commits lo=0x80000000, hi=0.
- hi/lo hold their value in every cycle that has no commit and no write.
- Counter wrap is impossible: cnt resets to 0 on each start.

Test Plan:
- Reset: drive rst=0 mid-CALC of MULTU 7*9 → hi=lo=0, busy=0 immediately; after release, no done pulse and hi/lo stay 0.
- MULT a=0xFFFFFFFD(-3), b=5 → busy for 33 cycles; done one cycle; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Issue DIVU 100/7 in the done cycle → accepted; then hi=2, lo=14.
- DIV a=0xFFFFFFF9(-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → after 33 cycles hi=0x1234, lo=0xFFFFFFFF.
- Idle writes and ignored inputs:
  - In IDLE: hi_we=1, wd=0xAAAA → hi=0xAAAA next cycle; lo_we=1, wd=0x5555 → lo=0x5555 next cycle.
  - Start MULTU 2*3, then during busy pulse start (op=DIVU) and lo_we → both ignored; final hi=0, lo=6.
